// File: rtl/fwd_scoreboard_unit_pkg.sv
// Shared constants and width helper for the operand-forwarding / scoreboard block.
package fwd_scoreboard_unit_pkg;

  localparam int unsigned FWD_RF         = 0;
  localparam int unsigned FWD_STAGE_BASE = 1;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  // Bits needed to hold 0..max_val; never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_unit_select.sv
// Priority forwarding match for one source operand: the youngest matching producer wins.
module fwd_select
  import fwd_scoreboard_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SEL_W   = idx_width(NUM_FWD)
) (
  input  logic [ADDR_W-1:0]         src_addr_i,
  input  logic [NUM_FWD-1:0]        regwrite_i,
  input  logic [NUM_FWD*ADDR_W-1:0] rd_i,
  output logic [SEL_W-1:0]          sel_o
);

  logic found;

  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!found && regwrite_i[k] &&
          (rd_i[k*ADDR_W +: ADDR_W] != '0) &&
          (rd_i[k*ADDR_W +: ADDR_W] == src_addr_i)) begin
        sel_o = SEL_W'(k + FWD_STAGE_BASE);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding selects plus a per-register latency scoreboard that stalls ID
// while any read source still has an outstanding multi-cycle write.
module fwd_scoreboard_unit
  import fwd_scoreboard_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned MAX_LAT = 3,
  localparam int unsigned CNT_W  = idx_width(MAX_LAT),
  localparam int unsigned SEL_W  = idx_width(NUM_FWD)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr_i,
  input  logic [NUM_FWD-1:0]        fwd_regwrite_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_rd_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
  input  logic [NUM_SRC-1:0]        id_src_valid_i,
  input  logic                      issue_valid_i,
  input  logic                      issue_regwrite_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  input  logic [CNT_W-1:0]          issue_lat_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [15:0]               stall_cnt_o
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             issue_acc;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_select #(
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
    ) u_sel (
      .src_addr_i (ex_src_addr_i[s*ADDR_W +: ADDR_W]),
      .regwrite_i (fwd_regwrite_i),
      .rd_i       (fwd_rd_i),
      .sel_o      (fwd_sel_o[s*SEL_W +: SEL_W])
    );
  end

  always_comb begin
    stall_o = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (id_src_valid_i[s] && (pend_q[id_src_addr_i[s*ADDR_W +: ADDR_W]] != '0)) begin
        stall_o = 1'b1;
      end
    end
  end

  assign issue_acc = issue_valid_i && !stall_o && issue_regwrite_i && (issue_rd_i != '0);

  // Entry 0 is never loaded, so it stays zero and r0 can never stall.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = '0;
      if ((r != 0) && !flush_i) begin
        if (issue_acc && (issue_rd_i == ADDR_W'(r))) begin
          pend_d[r] = issue_lat_i;
        end else if (pend_q[r] != '0) begin
          pend_d[r] = pend_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_fwd_scoreboard_unit;

  localparam int unsigned AW     = 5;
  localparam int unsigned CW     = 2;
  localparam int unsigned SAT_CW = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ex_src, fwd_rd, id_src;
  logic [1:0]  fwd_we, id_val, iss_lat;
  logic [3:0]  fwd_sel;
  logic        iss_v, iss_we, flush, stall;
  logic [4:0]  iss_rd;
  logic [15:0] scnt;

  logic [9:0]        s_ex_src, s_fwd_rd, s_id_src;
  logic [1:0]        s_fwd_we, s_id_val;
  logic [3:0]        s_fwd_sel;
  logic              s_iss_v, s_iss_we, s_flush, s_stall;
  logic [4:0]        s_iss_rd;
  logic [SAT_CW-1:0] s_iss_lat;
  logic [15:0]       s_scnt;

  always #5 clk = ~clk;

  fwd_scoreboard_unit #(.ADDR_W(AW), .NUM_SRC(2), .NUM_FWD(2), .MAX_LAT(3)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .ex_src_addr_i(ex_src), .fwd_regwrite_i(fwd_we),
    .fwd_rd_i(fwd_rd), .fwd_sel_o(fwd_sel), .id_src_addr_i(id_src), .id_src_valid_i(id_val),
    .issue_valid_i(iss_v), .issue_regwrite_i(iss_we), .issue_rd_i(iss_rd),
    .issue_lat_i(iss_lat), .flush_i(flush), .stall_o(stall), .stall_cnt_o(scnt)
  );

  // Long-latency instance used to hold stall high long enough to saturate the counter.
  fwd_scoreboard_unit #(.ADDR_W(AW), .NUM_SRC(2), .NUM_FWD(2), .MAX_LAT(131071)) u_dut_sat (
    .clk_i(clk), .rst_i(rst_n), .ex_src_addr_i(s_ex_src), .fwd_regwrite_i(s_fwd_we),
    .fwd_rd_i(s_fwd_rd), .fwd_sel_o(s_fwd_sel), .id_src_addr_i(s_id_src), .id_src_valid_i(s_id_val),
    .issue_valid_i(s_iss_v), .issue_regwrite_i(s_iss_we), .issue_rd_i(s_iss_rd),
    .issue_lat_i(s_iss_lat), .flush_i(s_flush), .stall_o(s_stall), .stall_cnt_o(s_scnt)
  );

  typedef struct {
    int          kind;
    int unsigned exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input int kind, input int unsigned v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    int unsigned act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = {31'b0, stall};
        1:       act = {16'b0, scnt};
        2:       act = {30'b0, fwd_sel[1:0]};
        3:       act = {30'b0, fwd_sel[3:2]};
        4:       act = {31'b0, s_stall};
        default: act = {16'b0, s_scnt};
      endcase
      checks++;
      if (act != e.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_src = '0; fwd_we = '0; fwd_rd = '0; id_src = '0; id_val = '0;
    iss_v = 1'b0; iss_we = 1'b0; iss_rd = '0; iss_lat = '0; flush = 1'b0;
  endtask

  task automatic s_idle();
    s_ex_src = '0; s_fwd_we = '0; s_fwd_rd = '0; s_id_src = '0; s_id_val = '0;
    s_iss_v = 1'b0; s_iss_we = 1'b0; s_iss_rd = '0; s_iss_lat = '0; s_flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    ex_src = 10'($urandom()); fwd_we = 2'($urandom()); fwd_rd = 10'($urandom());
    id_src = 10'($urandom()); id_val = 2'($urandom()); iss_v = 1'($urandom());
    iss_we = 1'($urandom()); iss_rd = 5'($urandom()); iss_lat = 2'($urandom());
    flush = 1'($urandom());
    s_ex_src = 10'($urandom()); s_fwd_we = 2'($urandom()); s_fwd_rd = 10'($urandom());
    s_id_src = 10'($urandom()); s_id_val = 2'($urandom()); s_iss_v = 1'($urandom());
    s_iss_we = 1'($urandom()); s_iss_rd = 5'($urandom()); s_iss_lat = SAT_CW'($urandom());
    s_flush = 1'($urandom());
  endtask

  task automatic issue(input logic [4:0] rd, input logic [CW-1:0] lat);
    iss_v = 1'b1; iss_we = 1'b1; iss_rd = rd; iss_lat = lat;
  endtask

  initial begin
    rst_n = 1'b0;
    randomize_inputs();
    step();
    randomize_inputs();
    push_exp(0, 0, "rst_stall"); push_exp(1, 0, "rst_cnt");
    push_exp(4, 0, "rst_sat_stall"); push_exp(5, 0, "rst_sat_cnt");
    step();

    rst_n = 1'b1; idle(); s_idle();
    id_val = 2'b11; id_src = 10'($urandom());
    push_exp(0, 0, "post_rst_all_valid_stall"); push_exp(1, 0, "post_rst_cnt");
    step();

    // Forwarding priority
    idle();
    ex_src = {5'd0, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11;
    push_exp(2, 1, "fwd_youngest_wins"); push_exp(3, 0, "fwd_src1_r0_none");
    step();
    fwd_we = 2'b10;
    push_exp(2, 2, "fwd_oldest_only");
    step();
    ex_src = {5'd12, 5'd0}; fwd_rd = {5'd5, 5'd0}; fwd_we = 2'b11;
    push_exp(2, 0, "fwd_r0_never"); push_exp(3, 0, "fwd_no_match");
    step();
    ex_src = {5'd12, 5'd5}; fwd_rd = {5'd5, 5'd12}; fwd_we = 2'b11;
    push_exp(2, 2, "fwd_mix_src0"); push_exp(3, 1, "fwd_mix_src1");
    step();
    fwd_we = 2'b00;
    push_exp(2, 0, "fwd_no_we_src0"); push_exp(3, 0, "fwd_no_we_src1");
    step();

    // Load-use, latency 1
    idle(); issue(5'd7, 2'd1);
    push_exp(0, 0, "r7_issue_stall");
    step();
    idle(); id_val = 2'b01; id_src = {5'd0, 5'd7};
    push_exp(0, 1, "r7_dep_stall"); push_exp(1, 0, "r7_cnt_during");
    step();
    push_exp(0, 0, "r7_released"); push_exp(1, 1, "r7_cnt_after");
    step();

    // Latency 3 with issue attempts during the stall
    idle(); issue(5'd3, 2'd3);
    push_exp(0, 0, "r3_issue_stall");
    step();
    id_val = 2'b10; id_src = {5'd3, 5'd0};
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1, "r3_stall"); push_exp(1, 1 + i, "r3_cnt");
      step();
    end
    iss_v = 1'b0;
    push_exp(0, 0, "r3_no_reload"); push_exp(1, 4, "r3_cnt_after");
    step();

    // Flush
    idle(); issue(5'd9, 2'd3);
    step();
    idle(); flush = 1'b1; id_val = 2'b01; id_src = {5'd0, 5'd9};
    push_exp(0, 1, "r9_stall_in_flush"); push_exp(1, 4, "r9_cnt_in_flush");
    step();
    flush = 1'b0;
    push_exp(0, 0, "r9_cleared"); push_exp(1, 5, "flush_cnt_still_incr");
    step();
    idle(); flush = 1'b1; issue(5'd11, 2'd2);
    push_exp(0, 0, "r11_flush_issue_stall");
    step();
    idle(); id_val = 2'b01; id_src = {5'd0, 5'd11};
    push_exp(0, 0, "r11_discarded");
    step();

    // Re-issue overrides decrement
    idle(); issue(5'd4, 2'd3);
    step();
    idle();
    step();
    issue(5'd4, 2'd3);
    push_exp(0, 0, "r4_reissue_stall");
    step();
    idle(); id_val = 2'b01; id_src = {5'd0, 5'd4};
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1, "r4_reloaded_stall"); push_exp(1, 5 + i, "r4_cnt");
      step();
    end
    push_exp(0, 0, "r4_released"); push_exp(1, 8, "r4_cnt_after");
    step();

    // Reset mid-stall
    idle(); issue(5'd6, 2'd3);
    push_exp(1, 8, "r6_cnt_before");
    step();
    idle(); id_val = 2'b01; id_src = {5'd0, 5'd6}; rst_n = 1'b0;
    push_exp(0, 1, "r6_stall_before_rst");
    step();
    rst_n = 1'b1;
    push_exp(0, 0, "r6_stall_after_rst"); push_exp(1, 0, "r6_cnt_after_rst");
    step();

    // Saturation on the long-latency instance
    idle(); s_idle();
    s_iss_v = 1'b1; s_iss_we = 1'b1; s_iss_rd = 5'd1; s_iss_lat = SAT_CW'(70000);
    push_exp(4, 0, "sat_issue_stall");
    step();
    s_idle(); s_id_val = 2'b01; s_id_src = {5'd0, 5'd1};
    for (int i = 1; i <= 65541; i++) begin
      if (i == 1) begin
        push_exp(4, 1, "sat_stall_start"); push_exp(5, 0, "sat_cnt_start");
      end
      if (i == 65535) push_exp(5, 65534, "sat_cnt_below_max");
      if (i == 65536) push_exp(5, 65535, "sat_cnt_reach_max");
      if (i == 65541) begin
        push_exp(4, 1, "sat_stall_held"); push_exp(5, 65535, "sat_cnt_hold");
      end
      step();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
